pipelined_sum_acc: RTL and testbench

PIPELINED_SUM_ACC -- requirements
Module: pipelined_sum_acc

---
 rtl/pipelined_sum_acc_if.sv | 30 +++
 rtl/pipelined_sum_acc.sv | 96 +++++++++
 tb/tb_pipelined_sum_acc.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_sum_acc_if.sv
// Operand/result bundle for pipelined_sum_acc: the source drives operands and
// controls, the sum pipeline drives results and accumulator state.
interface pipelined_sum_acc_if #(
    parameter int DW = 4,
    parameter int AW = 8
);
    logic          valid_in;
    logic          hold;
    logic          sel;
    logic [1:0]    mode;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic [DW-1:0] data_c;
    logic [DW-1:0] data_d;
    logic [DW+1:0] data_out1;
    logic [DW+1:0] data_out2;
    logic          valid_out;
    logic [AW-1:0] acc_out;
    logic          acc_sat;

    modport master (
        output valid_in, hold, sel, mode, data_a, data_b, data_c, data_d,
        input  data_out1, data_out2, valid_out, acc_out, acc_sat
    );

    modport slave (
        input  valid_in, hold, sel, mode, data_a, data_b, data_c, data_d,
        output data_out1, data_out2, valid_out, acc_out, acc_sat
    );
endinterface

// File: rtl/pipelined_sum_acc.sv
// Three-stage unsigned adder tree (a+b, +c, +d) with a saturating accumulator
// fed by the selected sum as it lands in the output stage.
module pipelined_sum_acc #(
    parameter int DW = 4,
    parameter int AW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pipelined_sum_acc_if.slave   bus
);
    localparam int SW = DW + 2;

    typedef struct packed {
        logic [DW:0]   s1;
        logic [DW-1:0] c;
        logic [DW-1:0] d;
        logic          sel;
        logic [1:0]    mode;
    } st1_t;

    typedef struct packed {
        logic [SW-1:0] s2;
        logic [DW:0]   s1;
        logic [DW-1:0] d;
        logic          sel;
        logic [1:0]    mode;
    } st2_t;

    st1_t          st1;
    st2_t          st2;
    logic [3:1]    vld_pipe;
    logic [SW-1:0] out1, out2, out1_next;
    logic [AW-1:0] acc, acc_next;
    logic          sat, sat_next;
    logic [AW:0]   acc_sum;

    // One extra bit on the sum so a carry out of the accumulator is seen exactly.
    always_comb begin
        out1_next = st2.sel ? SW'(st2.s1) : st2.s2 + SW'(st2.d);
        acc_sum   = {1'b0, acc} + (AW+1)'(out1_next);
        acc_next  = acc;
        sat_next  = sat;
        case (st2.mode)
            2'b01: begin
                if (acc_sum[AW]) begin
                    acc_next = '1;
                    sat_next = 1'b1;
                end else begin
                    acc_next = acc_sum[AW-1:0];
                end
            end
            2'b10: begin
                acc_next = AW'(out1_next);
                sat_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st1      <= '0;
            st2      <= '0;
            vld_pipe <= '0;
            out1     <= '0;
            out2     <= '0;
            acc      <= '0;
            sat      <= 1'b0;
        end else if (!bus.hold) begin
            st1.s1   <= (DW+1)'(bus.data_a) + (DW+1)'(bus.data_b);
            st1.c    <= bus.data_c;
            st1.d    <= bus.data_d;
            st1.sel  <= bus.sel;
            st1.mode <= bus.mode;
            st2.s2   <= SW'(st1.s1) + SW'(st1.c);
            st2.s1   <= st1.s1;
            st2.d    <= st1.d;
            st2.sel  <= st1.sel;
            st2.mode <= st1.mode;
            vld_pipe <= {vld_pipe[2:1], bus.valid_in};
            out2     <= st2.s2;
            out1     <= out1_next;
            // Data registers load every cycle; only the accumulator is gated on valid.
            if (vld_pipe[2]) begin
                acc <= acc_next;
                sat <= sat_next;
            end
        end
    end

    assign bus.data_out1 = out1;
    assign bus.data_out2 = out2;
    assign bus.valid_out = vld_pipe[3];
    assign bus.acc_out   = acc;
    assign bus.acc_sat   = sat;
endmodule

// File: tb/tb_pipelined_sum_acc.sv
// Bench for pipelined_sum_acc: a reference model queues expected results as
// operands are driven; a negedge monitor pops and compares each result.
module tb_pipelined_sum_acc;
    localparam int DW = 4;
    localparam int AW = 8;
    localparam int ACC_MAX = (1 << AW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    pipelined_sum_acc_if #(.DW(DW), .AW(AW)) bus();

    pipelined_sum_acc #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int o1;
        int o2;
        int acc;
        bit sat;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   m_acc = 0;
    bit   m_sat = 1'b0;
    int   adv = 0;
    bit   held_last = 1'b0;

    // adv counts edges on which the pipeline actually advanced.
    always @(posedge clk) begin
        held_last <= bus.hold;
        if (reset && !bus.hold) adv <= adv + 1;
    end

    initial begin
        cur = '{0, 0, 0, 1'b0, 0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (bus.valid_out !== 1'b0 || bus.data_out1 !== '0 || bus.data_out2 !== '0 ||
                    bus.acc_out !== '0 || bus.acc_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL in_reset got v=%0b o1=%0d o2=%0d acc=%0d sat=%0b want all 0",
                             bus.valid_out, bus.data_out1, bus.data_out2, bus.acc_out, bus.acc_sat);
                end
                cur = '{0, 0, 0, 1'b0, 0};
            end else begin
                if (bus.valid_out === 1'b1 && !held_last) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid got valid_out=1 o1=%0d want no result",
                                 bus.data_out1);
                    end else begin
                        cur = q.pop_front();
                        if (bus.data_out1 !== 6'(cur.o1) || bus.data_out2 !== 6'(cur.o2) ||
                            adv != cur.due) begin
                            errors++;
                            $display("FAIL result got o1=%0d o2=%0d slot=%0d want o1=%0d o2=%0d slot=%0d",
                                     bus.data_out1, bus.data_out2, adv, cur.o1, cur.o2, cur.due);
                        end
                    end
                end else if (bus.valid_out === 1'b1) begin
                    checks++;
                    if (bus.data_out1 !== 6'(cur.o1) || bus.data_out2 !== 6'(cur.o2)) begin
                        errors++;
                        $display("FAIL hold_freeze got o1=%0d o2=%0d want o1=%0d o2=%0d",
                                 bus.data_out1, bus.data_out2, cur.o1, cur.o2);
                    end
                end
                checks++;
                if (bus.acc_out !== 8'(cur.acc) || bus.acc_sat !== cur.sat) begin
                    errors++;
                    $display("FAIL acc got acc=%0d sat=%0b want acc=%0d sat=%0b",
                             bus.acc_out, bus.acc_sat, cur.acc, cur.sat);
                end
            end
        end
    end

    task automatic send(input int a, input int b, input int c, input int d,
                        input bit s, input bit [1:0] m, input bit v);
        exp_t e;
        int   t;
        bus.data_a = 4'(a); bus.data_b = 4'(b); bus.data_c = 4'(c); bus.data_d = 4'(d);
        bus.sel = s; bus.mode = m; bus.valid_in = v; bus.hold = 1'b0;
        if (v) begin
            e.o2 = a + b + c;
            e.o1 = s ? (a + b) : (a + b + c + d);
            if (m == 2'b01) begin
                t = m_acc + e.o1;
                if (t > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    m_sat = 1'b1;
                end else m_acc = t;
            end else if (m == 2'b10) begin
                m_acc = e.o1;
                m_sat = 1'b0;
            end
            e.acc = m_acc;
            e.sat = m_sat;
            e.due = adv + 3;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 0, 0, 0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) idle(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
            q.delete();
        end
        idle(1);
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0; bus.hold = 1'b0; bus.sel = 1'b0; bus.mode = 2'b00;
        bus.data_a = '0; bus.data_b = '0; bus.data_c = '0; bus.data_d = '0;
        reset = 1'b0;
        #2;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out1 !== '0 || bus.acc_out !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b o1=%0d acc=%0d want 0 0 0",
                     bus.valid_out, bus.data_out1, bus.acc_out);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    task automatic test_basic();
        send(3, 4, 5, 6, 1'b0, 2'b00, 1'b1);
        idle(1);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got valid_out=%0b want 0", bus.valid_out);
        end
        idle(1);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out1 !== 6'd18 || bus.data_out2 !== 6'd12 ||
            bus.acc_out !== 8'd0) begin
            errors++;
            $display("FAIL basic_sum got v=%0b o1=%0d o2=%0d acc=%0d want 1 18 12 0",
                     bus.valid_out, bus.data_out1, bus.data_out2, bus.acc_out);
        end
        idle(1);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse got valid_out=%0b want 0", bus.valid_out);
        end
        drain();
    endtask

    task automatic test_sel();
        send(3, 4, 5, 6, 1'b1, 2'b00, 1'b1);
        idle(2);
        checks++;
        if (bus.data_out1 !== 6'd7 || bus.data_out2 !== 6'd12) begin
            errors++;
            $display("FAIL sel_two got o1=%0d o2=%0d want 7 12", bus.data_out1, bus.data_out2);
        end
        drain();
    endtask

    task automatic test_saturate();
        send(15, 15, 15, 15, 1'b0, 2'b10, 1'b1);
        for (int i = 0; i < 5; i++) send(15, 15, 15, 15, 1'b0, 2'b01, 1'b1);
        drain();
        checks++;
        if (bus.acc_out !== 8'd255 || bus.acc_sat !== 1'b1) begin
            errors++;
            $display("FAIL saturate got acc=%0d sat=%0b want 255 1", bus.acc_out, bus.acc_sat);
        end
        send(15, 15, 15, 15, 1'b0, 2'b10, 1'b1);
        drain();
        checks++;
        if (bus.acc_out !== 8'd60 || bus.acc_sat !== 1'b0) begin
            errors++;
            $display("FAIL reload got acc=%0d sat=%0b want 60 0", bus.acc_out, bus.acc_sat);
        end
    endtask

    task automatic test_hold();
        send(1, 2, 3, 4, 1'b0, 2'b10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                bus.hold = 1'b1; bus.valid_in = 1'b1; bus.mode = 2'b10;
                bus.data_a = 4'd9; bus.sel = 1'b1;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(i, i + 1, 2 * i, 15 - i, i[0], 2'b01, 1'b1);
        end
        drain();
    endtask

    task automatic test_alternating();
        send(2, 2, 2, 2, 1'b0, 2'b10, 1'b1);
        for (int i = 0; i < 10; i++) send(i, 1, 2, 3, 1'b0, 2'b01, i[0] == 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0);
        drain();
    endtask

    task automatic test_reset_mid();
        send(1, 1, 1, 1, 1'b0, 2'b01, 1'b1);
        send(2, 2, 2, 2, 1'b0, 2'b01, 1'b1);
        send(3, 3, 3, 3, 1'b1, 2'b10, 1'b1);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out1 !== '0 || bus.data_out2 !== '0 ||
            bus.acc_out !== '0 || bus.acc_sat !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%0b o1=%0d o2=%0d acc=%0d want all 0",
                     bus.valid_out, bus.data_out1, bus.data_out2, bus.acc_out);
        end
        q.delete();
        m_acc = 0;
        m_sat = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        idle(6);
        send(5, 0, 0, 0, 1'b0, 2'b01, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel();
        test_saturate();
        test_hold();
        test_alternating();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
